i2c_adc_responder: RTL and testbench
====================================

I2C_ADC_RESPONDER -- requirements
Module: i2c_adc_responder

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'b1001001, I2C target address.
REQ-002 SHALL have parameter CONV_CYCLES, default 3000, clk_i cycles per emulated conversion.
REQ-003 SHALL have port clk_i, input, 1, the only clock.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port scl_i, input, 1, raw I2C clock.
REQ-006 SHALL have port sda_i, input, 1, raw I2C data.
REQ-007 SHALL have port sda_oe_o, output, 1; 1 pulls SDA low, 0 releases it.
REQ-008 SHALL have port sample_i, input, 16, analog value loaded at conversion end.
REQ-009 SHALL have port config_o, output, 16, current config register.
REQ-010 SHALL have port conv_done_o, output, 1, one-cycle pulse at conversion end.

Function
REQ-011 SHALL pass scl_i and sda_i through 2-FF synchronizers; all edge detection SHALL use synchronized values.
REQ-012 SHALL detect START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-013 SHALL sample SDA on SCL rising edges and change sda_oe_o only in the cycle after an SCL falling edge.
REQ-014 SHALL implement states IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR_DATA, ACK_WR, RD_DATA, RD_ACK and IGNORE.
REQ-015 START from any state SHALL go to ADDR with the bit counter cleared (repeated START included).
REQ-016 STOP from any state SHALL go to IDLE and set sda_oe_o to 0.
REQ-017 ADDR SHALL shift in 8 bits MSB first. On a match of bits[7:1] to ADDRESS it SHALL go to ACK_ADDR and drive ACK. On a mismatch it SHALL go to IGNORE without driving.
REQ-018 After ACK_ADDR with R/W=0, SHALL go to PTR. The received byte SHALL be ACKed, and pointer SHALL be set to byte[1:0].
REQ-019 After ACK_ADDR with R/W=1, SHALL copy the register selected by pointer into a 16-bit shift buffer and go to RD_DATA.
REQ-020 WR_DATA SHALL ACK every byte. Byte 1 SHALL be the MSB and byte 2 the LSB; the 16-bit write SHALL commit at the second ACK_WR.
REQ-021 Bytes beyond the second in a write SHALL be ACKed and discarded.
REQ-022 Writes to pointer 0, 2 or 3 SHALL be discarded while still ACKed.
REQ-023 RD_DATA SHALL drive buffer bits MSB first; for a 1 bit it SHALL release SDA (sda_oe_o=0).
REQ-024 In RD_ACK, a master ACK SHALL continue the read. Byte order SHALL wrap MSB, LSB, MSB of the same snapshot.
REQ-025 In RD_ACK, a master NACK SHALL go to IGNORE with SDA released.
REQ-026 Pointer 0 SHALL read the conversion register.
REQ-027 Pointer 1 SHALL read config with bit15 = ~busy.
REQ-028 Pointers 2 and 3 SHALL read 16'h0000.
REQ-029 A config commit with bit15=1 while not busy SHALL set busy and load the counter with CONV_CYCLES-1.
REQ-030 A config commit with bit15=1 while busy SHALL update config without restarting the counter.
REQ-031 When the counter reaches 0 while busy: conversion <= sample_i, busy <= 0, conv_done_o = 1 for one cycle.
REQ-032 Stored config bit15 SHALL always be 0; config_o[14:0] SHALL reflect the last commit.
REQ-033 If a read snapshot and a conversion end occur in the same cycle, the snapshot SHALL take the old conversion value.

Reset
REQ-034 On rst_i: state = IDLE, sda_oe_o = 0, pointer = 0, conversion = 16'h0000, config = 16'h0583, busy = 0, counter = 0, conv_done_o = 0, and synchronizers = 1.
REQ-035 Reset asserted mid-transaction SHALL release SDA on the next cycle and ignore bus activity until the next START.

Structure
REQ-036 A shared package SHALL hold the state enum, pointer codes (PTR_CONV=0, PTR_CFG=1), and CFG_RESET=16'h0583.
REQ-037 A sub-module i2c_edge_sync SHALL provide synchronization plus START, STOP, SCL-rise and SCL-fall detection.

Verification
REQ-038 Write address 0x92, pointer 0x01, data 0x85 0x83 -> every byte ACKed, busy=1; after CONV_CYCLES, conv_done_o pulses and conversion = sample_i (0x1234).
REQ-039 With conversion=0x1234, write pointer 0x00, repeated START, read 0x93 with ACK then NACK -> bytes 0x12 0x34, SDA released after the NACK.
REQ-040 Address 0x90 -> no ACK (SDA stays high through the 9th clock) and registers unchanged.
REQ-041 Read pointer 1 while busy -> 0x0583; after done -> 0x8583.
REQ-042 Assert rst_i during the second bit of a read data byte -> sda_oe_o=0 next cycle; the next transaction succeeds normally.
REQ-043 Read of 3 bytes with ACKs from pointer 0 (0xABCD) -> 0xAB 0xCD 0xAB.

Source files
------------

// File: rtl/i2c_adc_responder_pkg.sv
// Shared definitions for the I2C ADC responder: FSM states, pointer codes
// and the config register reset value.
package i2c_adc_responder_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    PTR,
    ACK_PTR,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic [1:0]  PTR_CONV  = 2'd0;
  localparam logic [1:0]  PTR_CFG   = 2'd1;
  localparam logic [15:0] CFG_RESET = 16'h0583;

endpackage

// File: rtl/i2c_edge_sync.sv
// Two-flop synchronizers for SCL/SDA plus bus-condition and SCL edge detection.
// All outputs are derived from synchronized samples only.
module i2c_edge_sync
  import i2c_adc_responder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // Synchronizer chains plus one history stage; idle bus level is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign sda_o      = sda_sync_q[1];
  assign start_o    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
  assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
  assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;

endmodule

// File: rtl/i2c_adc_responder.sv
// I2C target emulating a simple ADC: pointer register selects conversion,
// config or two zero registers; a config write with bit15 set starts a
// timed conversion that latches sample_i when it ends.
module i2c_adc_responder
  import i2c_adc_responder_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'b1001001,
  parameter int         CONV_CYCLES = 3000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] sample_i,
  output logic [15:0] config_o,
  output logic        conv_done_o
);

  localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;

  logic sda_s, start_s, stop_s, scl_rise_s, scl_fall_s;

  i2c_edge_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .start_o    (start_s),
    .stop_o     (stop_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s)
  );

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        sda_oe_q, sda_oe_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        mack_q, mack_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  wr_hi_q, wr_hi_d;
  logic [15:0] rd_buf_q, rd_buf_d;

  logic [15:0]      conv_q, cfg_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  logic        commit;
  logic [15:0] snapshot;

  // Register view seen by the master; config bit15 reports "not busy".
  function automatic logic [15:0] read_reg(input logic [1:0] ptr, input logic [15:0] conv,
                                           input logic [15:0] cfg, input logic busy);
    case (ptr)
      PTR_CONV: read_reg = conv;
      PTR_CFG:  read_reg = {~busy, cfg[14:0]};
      default:  read_reg = 16'h0000;
    endcase
  endfunction

  assign snapshot = read_reg(ptr_q, conv_q, cfg_q, busy_q);

  // Protocol FSM: shift on SCL rise, act on SCL fall so SDA only moves while SCL is low.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sda_oe_d   = sda_oe_q;
    ptr_d      = ptr_q;
    byte_idx_d = byte_idx_q;
    mack_d     = mack_q;
    shift_d    = shift_q;
    wr_hi_d    = wr_hi_q;
    rd_buf_d   = rd_buf_q;
    commit     = 1'b0;
    if (stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise_s && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              ADDR: begin
                if (shift_q[7:1] == ADDRESS) begin
                  state_d  = ACK_ADDR;
                  sda_oe_d = 1'b1;
                end else begin
                  state_d  = IGNORE;
                end
              end
              PTR: begin
                state_d  = ACK_PTR;
                sda_oe_d = 1'b1;
                ptr_d    = shift_q[1:0];
              end
              default: begin
                state_d  = ACK_WR;
                sda_oe_d = 1'b1;
                if (byte_idx_q == 2'd0) begin
                  wr_hi_d    = shift_q;
                  byte_idx_d = 2'd1;
                end else if (byte_idx_q == 2'd1) begin
                  commit     = (ptr_q == PTR_CFG);
                  byte_idx_d = 2'd2;
                end
              end
            endcase
          end
        end
        ACK_ADDR: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = RD_DATA;
              rd_buf_d = snapshot;
              sda_oe_d = ~snapshot[15];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        ACK_PTR: begin
          if (scl_fall_s) begin
            state_d    = WR_DATA;
            sda_oe_d   = 1'b0;
            byte_idx_d = 2'd0;
          end
        end
        ACK_WR: begin
          if (scl_fall_s) begin
            state_d  = WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
        RD_DATA: begin
          // Rotating the buffer makes the byte order wrap MSB, LSB, MSB.
          if (scl_fall_s) begin
            rd_buf_d = {rd_buf_q[14:0], rd_buf_q[15]};
            if (bit_cnt_q == 4'd7) begin
              state_d   = RD_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              sda_oe_d  = ~rd_buf_q[14];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise_s) begin
            mack_d = ~sda_s;
          end else if (scl_fall_s) begin
            if (mack_q) begin
              state_d  = RD_DATA;
              sda_oe_d = ~rd_buf_q[15];
            end else begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      sda_oe_q   <= 1'b0;
      ptr_q      <= PTR_CONV;
      byte_idx_q <= 2'd0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      ptr_q      <= ptr_d;
      byte_idx_q <= byte_idx_d;
      mack_q     <= mack_d;
    end
  end

  // Byte shift, write holding and read buffers; only meaningful once loaded.
  always_ff @(posedge clk_i) begin
    shift_q  <= shift_d;
    wr_hi_q  <= wr_hi_d;
    rd_buf_q <= rd_buf_d;
  end

  // Config commit and conversion timer; stored config bit15 is always zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conv_q <= 16'h0000;
      cfg_q  <= CFG_RESET;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (cnt_q == '0) begin
          conv_q <= sample_i;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
      if (commit) begin
        cfg_q <= {1'b0, wr_hi_q[6:0], shift_q};
        if (wr_hi_q[7] && !busy_q) begin
          busy_q <= 1'b1;
          cnt_q  <= CNT_W'(CONV_CYCLES - 1);
        end
      end
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign config_o    = cfg_q;
  assign conv_done_o = done_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Bench for i2c_adc_responder: bit-banged I2C master, register-level model
// and randomized write/read/address traffic.
module tb_i2c_adc_responder;

  localparam int         CONV = 2000;
  localparam int         Q    = 6;
  localparam logic [6:0] ADR  = 7'h49;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m;
  logic        sda_m;
  logic [15:0] sample;
  wire         sda_oe;
  wire         conv_done;
  wire  [15:0] cfg_o;
  wire         sda_line = sda_m & ~sda_oe;

  i2c_adc_responder #(.ADDRESS(ADR), .CONV_CYCLES(CONV)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .sample_i    (sample),
    .config_o    (cfg_o),
    .conv_done_o (conv_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  // Register-level model.
  logic [15:0] m_conv;
  logic [14:0] m_cfg;
  bit          m_busy;

  always @(posedge clk) if (conv_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q);
      scl_m = 1'b1; tick(2 * Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_line;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl_m = 1'b1; tick(Q);
      b[i] = sda_line;
      tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = ~ack; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1;
  endtask

  function automatic logic [15:0] model_reg(input logic [1:0] p);
    if (p == 2'd0) return m_conv;
    if (p == 2'd1) return {~m_busy, m_cfg};
    return 16'h0000;
  endfunction

  task automatic wr_txn(input logic [6:0] a, input logic [7:0] ptr, input logic [15:0] d,
                        input int nd, input string tag);
    bit ack;
    logic [7:0] b;
    bus_start;
    send_byte({a, 1'b0}, ack);
    if (a != ADR) begin
      chk({tag, "_noack"}, ack, 0);
      bus_stop;
      return;
    end
    chk({tag, "_aack"}, ack, 1);
    send_byte(ptr, ack);
    chk({tag, "_pack"}, ack, 1);
    for (int i = 0; i < nd; i++) begin
      b = (i == 0) ? d[15:8] : (i == 1) ? d[7:0] : 8'($urandom);
      send_byte(b, ack);
      chk({tag, "_dack"}, ack, 1);
    end
    bus_stop;
    if (nd >= 2 && ptr[1:0] == 2'd1) begin
      m_cfg = d[14:0];
      if (d[15]) m_busy = 1'b1;
    end
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int nb, input string tag);
    bit ack;
    logic [7:0] b;
    logic [15:0] exp;
    exp = model_reg(ptr[1:0]);
    bus_start;
    send_byte({ADR, 1'b0}, ack);
    chk({tag, "_aack"}, ack, 1);
    send_byte(ptr, ack);
    chk({tag, "_pack"}, ack, 1);
    bus_start;
    send_byte({ADR, 1'b1}, ack);
    chk({tag, "_rack"}, ack, 1);
    for (int i = 0; i < nb; i++) begin
      recv_byte(i < nb - 1, b);
      chk({tag, "_byte"}, b, (i % 2 == 0) ? exp[15:8] : exp[7:0]);
    end
    chk({tag, "_rel"}, sda_oe, 0);
    bus_stop;
  endtask

  task automatic wait_done(input string tag);
    int s = done_cnt;
    int k = 0;
    while (done_cnt == s && k < CONV + 1000) begin
      tick(1);
      k++;
    end
    chk({tag, "_done"}, done_cnt != s, 1);
    tick(1);
    chk({tag, "_pulse"}, conv_done, 0);
    m_conv = sample;
    m_busy = 1'b0;
  endtask

  initial begin
    bit ack;
    int op;
    logic [15:0] v;
    logic [7:0] p;
    logic [6:0] a;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; sample = 16'h1234;
    tick(4);
    rst = 1'b0;
    tick(2);
    m_conv = 16'h0000; m_cfg = 15'h0583; m_busy = 1'b0;
    chk("rst_oe", sda_oe, 0);
    chk("rst_cfg", cfg_o, 16'h0583);
    chk("rst_done", conv_done, 0);

    // Config write starts a conversion; busy shows as bit15=0.
    wr_txn(ADR, 8'h01, 16'h8583, 2, "cfgw");
    chk("cfgw_cfg", cfg_o, 16'h0583);
    rd_txn(8'h01, 2, "busyrd");
    wait_done("conv1");
    rd_txn(8'h00, 2, "convrd");
    rd_txn(8'h01, 2, "idlerd");

    // Wrong address: no ACK, nothing changes.
    wr_txn(7'h48, 8'h01, 16'h1111, 2, "badadr");
    chk("badadr_cfg", cfg_o, 16'h0583);
    rd_txn(8'h01, 2, "badadr_rd");

    // Three-byte read wraps to the MSB again.
    sample = 16'hABCD;
    wr_txn(ADR, 8'h01, 16'h8583, 2, "cfgw2");
    wait_done("conv2");
    rd_txn(8'h00, 3, "wrap");

    // Extra write bytes are discarded; writes to conversion register ignored.
    wr_txn(ADR, 8'h01, 16'h0123, 3, "extra");
    chk("extra_cfg", cfg_o, 16'h0123);
    wr_txn(ADR, 8'h00, 16'hFFFF, 2, "convw");
    rd_txn(8'h00, 2, "convw_rd");

    // Reset during the second bit of a read data byte (pointer 2 -> all zero bits).
    wr_txn(ADR, 8'h02, 16'h0000, 0, "p2");
    bus_start;
    send_byte({ADR, 1'b1}, ack);
    chk("rst_rack", ack, 1);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    chk("rst_drive", sda_oe, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_release", sda_oe, 0);
    rst = 1'b0;
    tick(Q);
    bus_stop;
    m_conv = 16'h0000; m_cfg = 15'h0583; m_busy = 1'b0;
    chk("rst2_cfg", cfg_o, 16'h0583);
    rd_txn(8'h01, 2, "after_rst");

    // Randomized traffic against the model.
    for (int it = 0; it < 10; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          v = 16'($urandom);
          sample = 16'($urandom);
          wr_txn(ADR, {6'($urandom), 2'd1}, v, 2 + $urandom_range(0, 1), "r_cfg");
          chk("r_cfg_o", cfg_o, {1'b0, m_cfg});
          if (m_busy) begin
            rd_txn(8'h01, 2, "r_busy");
            wait_done("r_conv");
            rd_txn(8'h00, 2, "r_conv_rd");
          end
        end
        1: begin
          p = 8'($urandom);
          if (p[1:0] == 2'd1) p[1:0] = 2'd3;
          wr_txn(ADR, p, 16'($urandom), 2, "r_drop");
          rd_txn(p, $urandom_range(1, 3), "r_drop_rd");
        end
        2: begin
          rd_txn(8'($urandom), $urandom_range(1, 3), "r_rd");
        end
        default: begin
          a = 7'($urandom);
          if (a == ADR) a = a ^ 7'h01;
          wr_txn(a, 8'h01, 16'($urandom), 2, "r_bad");
          chk("r_bad_cfg", cfg_o, {1'b0, m_cfg});
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
